// File: rtl/nerv_mem_arbiter_if.sv
// Bundle of the I, D and memory-side signals around the arbiter.
// slave is the arbiter's view; master is the core/SPRAM view.
interface nerv_mem_arbiter_if #(
  parameter int ADDR_W = 14
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [31:0]       i_rdata;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [3:0]        d_wstrb;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic [31:0]       d_rdata;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_addr, d_wstrb, d_wdata,
    input  mem_rdata,
    output i_ack, i_rdata,
    output d_ack, d_rdata,
    output mem_en, mem_addr,
    output mem_wstrb, mem_wdata
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_addr, d_wstrb, d_wdata,
    output mem_rdata,
    input  i_ack, i_rdata,
    input  d_ack, d_rdata,
    input  mem_en, mem_addr,
    input  mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/nerv_mem_arbiter.sv
// Single-port SPRAM arbiter for the NERV I and D ports.
// D has priority; a D burst limit bounds I starvation.
module nerv_mem_arbiter #(
  parameter int ADDR_W      = 14,
  parameter int MAX_D_BURST = 4
) (
  input logic               clock,
  input logic               reset,
  nerv_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_I    = 2'd1,
    RESP_D    = 2'd2
  } resp_e;

  localparam logic [3:0] RUN_MAX = 4'(MAX_D_BURST);

  resp_e             resp_q;
  resp_e             resp_d;
  logic [3:0]        d_run_q;
  logic [3:0]        d_run_d;
  logic              grant_d;
  logic              grant_i;
  logic              burst_full;
  logic [ADDR_W-1:0] addr_sel;

  assign burst_full = bus.i_req & (d_run_q == RUN_MAX);

  // No grant can be issued while reset is held.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (!reset) begin
      grant_d = bus.d_req & ~burst_full;
      grant_i = bus.i_req & ~grant_d;
    end
  end

  always_comb begin
    addr_sel = bus.i_addr;
    if (grant_d) begin
      addr_sel = bus.d_addr;
    end
  end

  assign bus.mem_en    = grant_d | grant_i;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wstrb = grant_d ? bus.d_wstrb : 4'h0;
  assign bus.mem_wdata = bus.d_wdata;

  always_comb begin
    resp_d  = RESP_NONE;
    d_run_d = d_run_q;
    unique case (1'b1)
      grant_d: resp_d = RESP_D;
      grant_i: resp_d = RESP_I;
      default: resp_d = RESP_NONE;
    endcase
    if (grant_d && bus.i_req) begin
      if (d_run_q != RUN_MAX) begin
        d_run_d = d_run_q + 4'd1;
      end
    end else if (grant_i || !bus.i_req) begin
      d_run_d = 4'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_q  <= RESP_NONE;
      d_run_q <= 4'd0;
    end else begin
      resp_q  <= resp_d;
      d_run_q <= d_run_d;
    end
  end

  assign bus.i_ack   = (resp_q == RESP_I);
  assign bus.d_ack   = (resp_q == RESP_D);
  assign bus.i_rdata = bus.i_ack ? bus.mem_rdata : 32'h0;
  assign bus.d_rdata = bus.d_ack ? bus.mem_rdata : 32'h0;

endmodule

// File: tb/tb_nerv_mem_arbiter.sv
// Bench for nerv_mem_arbiter: directed scenarios plus
// random traffic against a behavioural arbitration model.
module tb_nerv_mem_arbiter;
  localparam int AW   = 14;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nerv_mem_arbiter_if #(.ADDR_W(AW)) bus ();

  nerv_mem_arbiter #(
    .ADDR_W     (AW),
    .MAX_D_BURST(MAXB)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  logic [31:0] mem     [0:(1<<AW)-1];
  logic [31:0] ref_mem [0:(1<<AW)-1];
  int n_pass  = 0;
  int n_total = 0;

  task automatic preload(input int a, input logic [31:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  // SPRAM model: one-cycle read latency, byte writes.
  task automatic tick();
    logic          en;
    logic [AW-1:0] a;
    logic [3:0]    s;
    logic [31:0]   w;
    logic [31:0]   rd;
    en = bus.mem_en;
    a  = bus.mem_addr;
    s  = bus.mem_wstrb;
    w  = bus.mem_wdata;
    @(posedge clk);
    if (en === 1'b1) begin
      rd = mem[a];
      for (int b = 0; b < 4; b++)
        if (s[b]) mem[a][8*b +: 8] = w[8*b +: 8];
      bus.mem_rdata = rd;
    end
    #1;
  endtask

  task automatic idle();
    bus.i_req   = 1'b0;
    bus.d_req   = 1'b0;
    bus.d_wstrb = 4'h0;
    repeat (2) begin
      @(negedge clk);
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_req = 1'b1; bus.i_addr = 14'h1;
    bus.d_req = 1'b1; bus.d_addr = 14'h2;
    bus.d_wstrb = 4'hF; bus.d_wdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_total++;
      if (bus.mem_en !== 1'b0)
        $display("FAIL rst_mem_en c=%0d got %b want 0", c, bus.mem_en);
      else n_pass++;
      n_total++;
      if (bus.mem_wstrb !== 4'h0)
        $display("FAIL rst_wstrb c=%0d got %h want 0", c, bus.mem_wstrb);
      else n_pass++;
      n_total++;
      if ({bus.i_ack, bus.d_ack} !== 2'b00)
        $display("FAIL rst_acks c=%0d got %b want 00", c, {bus.i_ack, bus.d_ack});
      else n_pass++;
      n_total++;
      if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0)
        $display("FAIL rst_rdata c=%0d got %h/%h want 0", c, bus.i_rdata, bus.d_rdata);
      else n_pass++;
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.mem_en !== 1'b1 || bus.mem_addr !== 14'h2)
      $display("FAIL rst_first_grant got en=%b addr=%h want 1/2", bus.mem_en, bus.mem_addr);
    else n_pass++;
    tick();
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    bus.d_wstrb = 4'h0;
    @(negedge clk);
    n_total++;
    if (bus.d_ack !== 1'b1 || bus.i_ack !== 1'b0)
      $display("FAIL rst_first_ack got d=%b i=%b want 1/0", bus.d_ack, bus.i_ack);
    else n_pass++;
    tick();
  endtask

  task automatic test_i_only();
    preload(32'h10, 32'hDEADBEEF);
    bus.i_req = 1'b1; bus.i_addr = 14'h10;
    @(negedge clk);
    n_total++;
    if (bus.mem_en !== 1'b1 || bus.mem_addr !== 14'h10 || bus.mem_wstrb !== 4'h0)
      $display("FAIL i_only_drive got en=%b addr=%h ws=%h want 1/10/0",
               bus.mem_en, bus.mem_addr, bus.mem_wstrb);
    else n_pass++;
    tick();
    bus.i_req = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.i_ack !== 1'b1 || bus.i_rdata !== 32'hDEADBEEF || bus.d_ack !== 1'b0)
      $display("FAIL i_only_ack got ack=%b data=%h want 1/deadbeef", bus.i_ack, bus.i_rdata);
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if (bus.i_ack !== 1'b0 || bus.i_rdata !== 32'h0)
      $display("FAIL i_only_after got ack=%b data=%h want 0/0", bus.i_ack, bus.i_rdata);
    else n_pass++;
    tick();
  endtask

  task automatic test_d_write_read();
    preload(32'h20, 32'hAABBCCDD);
    bus.d_req = 1'b1; bus.d_addr = 14'h20;
    bus.d_wstrb = 4'b0101; bus.d_wdata = 32'h11223344;
    @(negedge clk);
    n_total++;
    if (bus.mem_en !== 1'b1 || bus.mem_wstrb !== 4'b0101)
      $display("FAIL dw_drive got en=%b ws=%b want 1/0101", bus.mem_en, bus.mem_wstrb);
    else n_pass++;
    tick();
    bus.d_wstrb = 4'h0;
    @(negedge clk);
    n_total++;
    if (bus.d_ack !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_wstrb !== 4'h0)
      $display("FAIL dw_ack got ack=%b en=%b ws=%h want 1/1/0",
               bus.d_ack, bus.mem_en, bus.mem_wstrb);
    else n_pass++;
    tick();
    bus.d_req = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.d_ack !== 1'b1 || bus.d_rdata !== 32'hAA22CC44)
      $display("FAIL dr_data got ack=%b data=%h want 1/aa22cc44", bus.d_ack, bus.d_rdata);
    else n_pass++;
    tick();
  endtask

  task automatic test_priority();
    bus.i_req = 1'b1; bus.i_addr = 14'h30;
    bus.d_req = 1'b1; bus.d_addr = 14'h31; bus.d_wstrb = 4'h0;
    @(negedge clk);
    n_total++;
    if (bus.mem_addr !== 14'h31 || bus.d_ack !== 1'b0)
      $display("FAIL prio_c0 got addr=%h dack=%b want 31/0", bus.mem_addr, bus.d_ack);
    else n_pass++;
    tick();
    @(negedge clk);
    n_total++;
    if (bus.mem_addr !== 14'h31 || bus.d_ack !== 1'b1)
      $display("FAIL prio_c1 got addr=%h dack=%b want 31/1", bus.mem_addr, bus.d_ack);
    else n_pass++;
    tick();
    bus.d_req = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.mem_en !== 1'b1 || bus.mem_addr !== 14'h30 || bus.i_ack !== 1'b0)
      $display("FAIL prio_c2 got en=%b addr=%h iack=%b want 1/30/0",
               bus.mem_en, bus.mem_addr, bus.i_ack);
    else n_pass++;
    tick();
    bus.i_req = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.i_ack !== 1'b1 || bus.mem_en !== 1'b0)
      $display("FAIL prio_c3 got iack=%b en=%b want 1/0", bus.i_ack, bus.mem_en);
    else n_pass++;
    tick();
  endtask

  task automatic test_starvation();
    logic          exp_i;
    logic [AW-1:0] exp_a;
    bus.i_req = 1'b1; bus.i_addr = 14'h40;
    bus.d_req = 1'b1; bus.d_addr = 14'h41; bus.d_wstrb = 4'h0;
    for (int c = 0; c < 15; c++) begin
      exp_i = (c % (MAXB + 1) == MAXB);
      exp_a = exp_i ? 14'h40 : 14'h41;
      @(negedge clk);
      n_total++;
      if (bus.mem_addr !== exp_a)
        $display("FAIL starve_grant c=%0d got %h want %h", c, bus.mem_addr, exp_a);
      else n_pass++;
      n_total++;
      if (bus.i_ack !== (c > 0 && c % (MAXB + 1) == 0))
        $display("FAIL starve_iack c=%0d got %b", c, bus.i_ack);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) preload(32'h100 + k, $urandom);
    for (int k = 0; k < 9; k++) begin
      bus.i_req  = (k < 8);
      bus.i_addr = 14'(32'h100 + k);
      @(negedge clk);
      if (k < 8) begin
        n_total++;
        if (bus.mem_en !== 1'b1 || bus.mem_addr !== 14'(32'h100 + k))
          $display("FAIL b2b_grant k=%0d got en=%b addr=%h", k, bus.mem_en, bus.mem_addr);
        else n_pass++;
      end
      if (k > 0) begin
        n_total++;
        if (bus.i_ack !== 1'b1 || bus.i_rdata !== ref_mem[32'h100 + k - 1])
          $display("FAIL b2b_ack k=%0d got ack=%b data=%h want 1/%h",
                   k, bus.i_ack, bus.i_rdata, ref_mem[32'h100 + k - 1]);
        else n_pass++;
      end
      tick();
    end
    @(negedge clk);
    n_total++;
    if (bus.i_ack !== 1'b0)
      $display("FAIL b2b_end got ack=%b want 0", bus.i_ack);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.i_req = 1'b1; bus.i_addr = 14'h50;
    bus.d_req = 1'b1; bus.d_addr = 14'h51; bus.d_wstrb = 4'h0;
    for (int c = 0; c < MAXB; c++) begin
      @(negedge clk);
      n_total++;
      if (bus.mem_addr !== 14'h51)
        $display("FAIL rmid_pre c=%0d got %h want 51", c, bus.mem_addr);
      else n_pass++;
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.mem_en !== 1'b0)
      $display("FAIL rmid_en got %b want 0", bus.mem_en);
    else n_pass++;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.mem_addr !== 14'h51 || bus.d_ack !== 1'b0 || bus.i_ack !== 1'b0)
      $display("FAIL rmid_post got addr=%h d=%b i=%b want 51/0/0",
               bus.mem_addr, bus.d_ack, bus.i_ack);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic          ip, dp, ei, ed, pi, pd, pwr;
    logic [AW-1:0] ia, da;
    logic [3:0]    ws;
    logic [31:0]   wd, pdat;
    int            streak;
    for (int a = 0; a < 64; a++) preload(a, $urandom);
    ip = 0; dp = 0; pi = 0; pd = 0; pwr = 0;
    ia = '0; da = '0; ws = '0; wd = '0; pdat = '0;
    streak = 0;
    for (int c = 0; c < 400; c++) begin
      if (!ip && $urandom_range(0, 9) < 6) begin
        ip = 1; ia = 14'($urandom_range(0, 63));
      end
      if (!dp && $urandom_range(0, 9) < 7) begin
        dp = 1; da = 14'($urandom_range(0, 63));
        ws = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
        wd = $urandom;
      end
      bus.i_req = ip; bus.i_addr = ia;
      bus.d_req = dp; bus.d_addr = da;
      bus.d_wstrb = ws; bus.d_wdata = wd;
      // D wins unless I has waited out a full D burst.
      ed = dp && !(ip && streak >= MAXB);
      ei = ip && !ed;
      @(negedge clk);
      n_total++;
      if (bus.mem_en !== (ed || ei))
        $display("FAIL rnd_en c=%0d got %b want %b", c, bus.mem_en, ed || ei);
      else n_pass++;
      if (ed || ei) begin
        n_total++;
        if (bus.mem_addr !== (ed ? da : ia) || bus.mem_wstrb !== (ed ? ws : 4'h0))
          $display("FAIL rnd_grant c=%0d got %h/%h want %h/%h", c,
                   bus.mem_addr, bus.mem_wstrb, ed ? da : ia, ed ? ws : 4'h0);
        else n_pass++;
      end
      n_total++;
      if (bus.i_ack !== pi || bus.d_ack !== pd)
        $display("FAIL rnd_ack c=%0d got i=%b d=%b want %b/%b",
                 c, bus.i_ack, bus.d_ack, pi, pd);
      else n_pass++;
      n_total++;
      if (bus.i_rdata !== (pi ? pdat : 32'h0))
        $display("FAIL rnd_irdata c=%0d got %h want %h",
                 c, bus.i_rdata, pi ? pdat : 32'h0);
      else n_pass++;
      if (!pd || !pwr) begin
        n_total++;
        if (bus.d_rdata !== (pd ? pdat : 32'h0))
          $display("FAIL rnd_drdata c=%0d got %h want %h",
                   c, bus.d_rdata, pd ? pdat : 32'h0);
        else n_pass++;
      end
      if (ed) begin
        pdat = ref_mem[da];
        for (int b = 0; b < 4; b++)
          if (ws[b]) ref_mem[da][8*b +: 8] = wd[8*b +: 8];
        pwr = (ws != 4'h0);
      end else if (ei) begin
        pdat = ref_mem[ia];
        pwr = 0;
      end
      if (ed && ip) streak = (streak < MAXB) ? streak + 1 : MAXB;
      else if (ei || !ip) streak = 0;
      pi = ei; pd = ed;
      if (ei) ip = 0;
      if (ed) dp = 0;
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_addr = '0;
    bus.d_wstrb = 4'h0; bus.d_wdata = 32'h0;
    bus.mem_rdata = 32'h0;
    test_reset();
    idle();
    test_i_only();
    idle();
    test_d_write_read();
    idle();
    test_priority();
    idle();
    test_starvation();
    idle();
    test_back_to_back();
    idle();
    test_reset_mid();
    idle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
